pldata_capture: RTL

PLDATA_CAPTURE -- requirements
Module: pldata_capture

---
 rtl/pldata_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pldata_capture.sv
// Frame capture engine: streams samples from one selected source into a
// two-bank RAM, with optional per-frame trigger and continuous ping-pong mode.
module pldata_capture #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data_in,
    input  logic [NUM_SRC-1:0]          src_valid_in,
    input  logic [SEL_W-1:0]            src_sel_in,
    input  logic [ADDR_W-4:0]           frame_len_in,
    input  logic                        cont_in,
    input  logic                        trig_en_in,
    input  logic                        trig_in,
    input  logic                        start_in,
    input  logic                        abort_in,
    input  logic [1:0]                  ack_in,
    output logic                        ram_wr_o,
    output logic [ADDR_W-1:0]           ram_addr_o,
    output logic [DATA_W-1:0]           ram_data_o,
    output logic                        done_o,
    output logic                        done_bank_o,
    output logic                        busy_o,
    output logic                        overflow_o
);

    localparam int LEN_W = ADDR_W - 3;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_idx;
    logic               cont_q;
    logic               trig_en_q;
    logic               bank;
    logic [1:0]         bank_full;
    logic               sel_valid;
    logic [DATA_W-1:0]  sel_data;

    // Out-of-range select values simply never capture anything.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_valid = src_valid_in[k];
                sel_data  = src_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= '0;
            len_q       <= '0;
            word_idx    <= '0;
            cont_q      <= 1'b0;
            trig_en_q   <= 1'b0;
            bank        <= 1'b0;
            bank_full   <= '0;
            ram_wr_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            done_o      <= 1'b0;
            done_bank_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            ram_wr_o <= 1'b0;
            done_o   <= 1'b0;
            // Abort freezes bank_full and overflow; it only drops the frame.
            if (abort_in) begin
                state <= IDLE;
            end else begin
                bank_full <= bank_full & ~ack_in;
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            sel_q      <= src_sel_in;
                            len_q      <= frame_len_in;
                            cont_q     <= cont_in;
                            trig_en_q  <= trig_en_in;
                            bank       <= 1'b0;
                            word_idx   <= '0;
                            bank_full  <= '0;
                            overflow_o <= 1'b0;
                            state      <= trig_en_in ? WAIT_TRIG : CAPTURE;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_in) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (sel_valid) begin
                            ram_wr_o   <= 1'b1;
                            ram_data_o <= sel_data;
                            ram_addr_o <= {bank, word_idx, 2'b00};
                            if (word_idx == len_q) begin
                                word_idx    <= '0;
                                done_o      <= 1'b1;
                                done_bank_o <= bank;
                                state       <= DONE;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // This set overrides a same-cycle ack of the same bank.
                        bank_full[bank] <= 1'b1;
                        if (!cont_q) begin
                            state <= IDLE;
                        end else begin
                            bank <= ~bank;
                            if (bank_full[~bank] && !ack_in[~bank]) begin
                                overflow_o <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= trig_en_q ? WAIT_TRIG : CAPTURE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
